// File: rtl/mestre_memoria.sv
// Memory-access initiator: PREPARA/ACESSO/LIBERA strobe sequencing with range check. Optional counters via MESTRE_MEMORIA_CONTADORES_EN.
// Latency CICLOS_ACESSO+2 cycles to resp_valido (1 for out-of-range); single outstanding request, req_pronto low while busy.
module mestre_memoria #(
    parameter int TAM_MEMORIA   = 1024,
    parameter int CICLOS_ACESSO = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valido,
    input  logic        req_escrita,
    input  logic [31:0] req_endereco,
    input  logic [31:0] req_dado,
    output logic        req_pronto,
    output logic        resp_valido,
    output logic        resp_erro,
    output logic [31:0] resp_dado,
    output logic [31:0] endereco,
    output logic [31:0] dado_escrita,
    output logic        uc_escrita_mem,
    output logic        uc_leitura_mem,
    input  logic [31:0] instrucao,
    output logic [15:0] cont_leituras,
    output logic [15:0] cont_escritas
);

    typedef enum logic [2:0] {OCIOSO, PREPARA, ACESSO, LIBERA, ERRO} estado_t;

    localparam logic [3:0]  CARGA  = 4'(CICLOS_ACESSO - 1);
    localparam logic [31:0] LIMITE = 32'(TAM_MEMORIA);

    estado_t    estado;
    logic       escrita_lat;
    logic [3:0] cont_acesso;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado         <= OCIOSO;
            escrita_lat    <= 1'b0;
            cont_acesso    <= 4'd0;
            req_pronto     <= 1'b1;
            resp_valido    <= 1'b0;
            resp_erro      <= 1'b0;
            resp_dado      <= 32'd0;
            endereco       <= 32'd0;
            dado_escrita   <= 32'd0;
            uc_escrita_mem <= 1'b0;
            uc_leitura_mem <= 1'b0;
        end else begin
            resp_valido <= 1'b0;
            resp_erro   <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (req_valido) begin
                        endereco     <= req_endereco;
                        dado_escrita <= req_dado;
                        escrita_lat  <= req_escrita;
                        req_pronto   <= 1'b0;
                        // Out-of-range requests report in the very next cycle and never reach memory.
                        if (req_endereco >= LIMITE) begin
                            estado      <= ERRO;
                            resp_valido <= 1'b1;
                            resp_erro   <= 1'b1;
                        end else begin
                            estado <= PREPARA;
                        end
                    end
                end
                PREPARA: begin
                    uc_escrita_mem <= escrita_lat;
                    uc_leitura_mem <= ~escrita_lat;
                    cont_acesso    <= CARGA;
                    estado         <= ACESSO;
                end
                ACESSO: begin
                    if (cont_acesso == 4'd0) begin
                        uc_escrita_mem <= 1'b0;
                        uc_leitura_mem <= 1'b0;
                        resp_valido    <= 1'b1;
                        if (!escrita_lat)
                            resp_dado <= instrucao;
                        estado <= LIBERA;
                    end else begin
                        cont_acesso <= cont_acesso - 4'd1;
                    end
                end
                LIBERA, ERRO: begin
                    req_pronto <= 1'b1;
                    estado     <= OCIOSO;
                end
                default: begin
                    uc_escrita_mem <= 1'b0;
                    uc_leitura_mem <= 1'b0;
                    req_pronto     <= 1'b1;
                    estado         <= OCIOSO;
                end
            endcase
        end
    end

`ifdef MESTRE_MEMORIA_CONTADORES_EN
    logic [15:0] leituras_q;
    logic [15:0] escritas_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leituras_q <= 16'd0;
            escritas_q <= 16'd0;
        end else if (estado == LIBERA) begin
            if (escrita_lat && escritas_q != 16'hFFFF)
                escritas_q <= escritas_q + 16'd1;
            if (!escrita_lat && leituras_q != 16'hFFFF)
                leituras_q <= leituras_q + 16'd1;
        end
    end

    assign cont_leituras = leituras_q;
    assign cont_escritas = escritas_q;
`else
    assign cont_leituras = 16'd0;
    assign cont_escritas = 16'd0;
`endif

endmodule
